// File: rtl/zoom_pkg.sv
// zoom_pkg: shared encodings for the pixel-replication zoom engine.
//   estado_t   - control FSM states (OCIOSO, VARRE, ESVAZIA, FIM)
//   FATOR_*    - zoom mode encodings carried on the fator port
//   limita     - clamps a window origin so the zoomed window stays inside the image
package zoom_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    VARRE   = 2'd1,
    ESVAZIA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [1:0] FATOR_1X        = 2'd0;
  localparam logic [1:0] FATOR_2X        = 2'd1;
  localparam logic [1:0] FATOR_4X        = 2'd2;
  localparam logic [1:0] FATOR_RESERVADO = 2'd3;

  // min(origem, dim - (dim >> k)); 32-bit so nothing truncates before the final resize.
  function automatic logic [31:0] limita(input logic [31:0] origem, input logic [31:0] dim,
                                         input logic [1:0] k);
    logic [31:0] lim;
    lim = dim - (dim >> k);
    return (origem > lim) ? lim : origem;
  endfunction

endpackage

// File: rtl/contador_varredura.sv
// contador_varredura: row-major x/y raster counter over a LARGURA x ALTURA frame.
//   clock, reset_n - clock and synchronous active-low reset
//   limpar         - synchronous clear to (0,0)
//   avancar        - step to the next pixel (x wraps to 0 and y increments)
//   x, y           - current pixel coordinates
//   ultimo         - high while (x,y) is the last pixel of the frame
module contador_varredura
  import zoom_pkg::*;
#(
  parameter int LARGURA = 320,
  parameter int ALTURA  = 240,
  localparam int X_W    = $clog2(LARGURA),
  localparam int Y_W    = $clog2(ALTURA)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           limpar,
  input  logic           avancar,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           ultimo
);

  logic fim_linha;
  logic fim_coluna;

  always_comb begin
    fim_linha  = (x == X_W'(LARGURA - 1));
    fim_coluna = (y == Y_W'(ALTURA - 1));
    ultimo     = fim_linha && fim_coluna;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || limpar) begin
      x <= '0;
      y <= '0;
    end else if (avancar) begin
      if (fim_linha) begin
        x <= '0;
        y <= fim_coluna ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ampliacao_replicacao.sv
// ampliacao_replicacao: zooms a window of the source image by 1x/2x/4x using pixel
// replication, streaming one output pixel per cycle from source RAM to destination RAM.
//   clock, reset_n             - clock and synchronous active-low reset
//   iniciar, fator             - start request and zoom mode (3 = reserved -> erro)
//   origem_x, origem_y         - source window top-left corner (clamped on accept)
//   end_leitura, ler           - source RAM read address / enable
//   pixel_lido                 - source RAM data, valid the cycle after ler
//   end_escrita, escrever      - destination RAM write address / enable
//   pixel_escrito              - destination RAM write data
//   ocupado, concluido, erro   - busy level, done pulse, error pulse
module ampliacao_replicacao
  import zoom_pkg::*;
#(
  parameter int LARGURA  = 320,
  parameter int ALTURA   = 240,
  parameter int PIXEL_W  = 8,
  localparam int X_W     = $clog2(LARGURA),
  localparam int Y_W     = $clog2(ALTURA),
  localparam int ADDR_W  = $clog2(LARGURA * ALTURA)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               iniciar,
  input  logic [1:0]         fator,
  input  logic [X_W-1:0]     origem_x,
  input  logic [Y_W-1:0]     origem_y,
  output logic [ADDR_W-1:0]  end_leitura,
  output logic               ler,
  input  logic [PIXEL_W-1:0] pixel_lido,
  output logic [ADDR_W-1:0]  end_escrita,
  output logic               escrever,
  output logic [PIXEL_W-1:0] pixel_escrito,
  output logic               ocupado,
  output logic               concluido,
  output logic               erro
);

  estado_t        estado;
  logic [1:0]     k_q;
  logic [X_W-1:0] x0_q;
  logic [Y_W-1:0] y0_q;
  logic [ADDR_W-1:0] dst_q;  // destination address of the read in flight

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           ultimo;

  logic [31:0] end_src;
  logic [31:0] end_dst;

  contador_varredura #(
    .LARGURA (LARGURA),
    .ALTURA  (ALTURA)
  ) u_contador (
    .clock   (clock),
    .reset_n (reset_n),
    .limpar  (estado == OCIOSO),
    .avancar (estado == VARRE),
    .x       (x),
    .y       (y),
    .ultimo  (ultimo)
  );

  always_comb begin
    end_src = (32'(y0_q) + (32'(y) >> k_q)) * 32'(LARGURA) + 32'(x0_q) + (32'(x) >> k_q);
    end_dst = 32'(y) * 32'(LARGURA) + 32'(x);
  end

  // RAM data arrives in the write cycle, so it is forwarded combinationally; gating keeps
  // the bus at 0 whenever no write is in progress (including reset).
  assign pixel_escrito = escrever ? pixel_lido : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      k_q         <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      dst_q       <= '0;
      end_leitura <= '0;
      end_escrita <= '0;
      ler         <= 1'b0;
      escrever    <= 1'b0;
      ocupado     <= 1'b0;
      concluido   <= 1'b0;
      erro        <= 1'b0;
    end else begin
      ler       <= 1'b0;
      escrever  <= ler;
      concluido <= 1'b0;
      erro      <= 1'b0;
      if (ler) begin
        end_escrita <= dst_q;
      end
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            if (fator == FATOR_RESERVADO) begin
              erro <= 1'b1;
            end else begin
              k_q     <= fator;
              x0_q    <= X_W'(limita(32'(origem_x), 32'(LARGURA), fator));
              y0_q    <= Y_W'(limita(32'(origem_y), 32'(ALTURA), fator));
              ocupado <= 1'b1;
              estado  <= VARRE;
            end
          end
        end
        VARRE: begin
          ler         <= 1'b1;
          end_leitura <= ADDR_W'(end_src);
          dst_q       <= ADDR_W'(end_dst);
          if (ultimo) begin
            estado <= ESVAZIA;
          end
        end
        ESVAZIA: begin
          // Only the last pending write remains in flight.
          estado <= FIM;
        end
        FIM: begin
          concluido <= 1'b1;
          ocupado   <= 1'b0;
          estado    <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ampliacao_replicacao.sv
module tb_ampliacao_replicacao;

  localparam int L = 8;
  localparam int A = 4;
  localparam int N_PIX = L * A;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] fator = 2'd0;
  logic [2:0] origem_x = '0;
  logic [1:0] origem_y = '0;
  logic [4:0] end_leitura;
  logic       ler;
  logic [7:0] pixel_lido;
  logic [4:0] end_escrita;
  logic       escrever;
  logic [7:0] pixel_escrito;
  logic       ocupado;
  logic       concluido;
  logic       erro;

  logic [7:0] src_mem [N_PIX];
  logic [7:0] dst_mem [N_PIX];
  logic [7:0] rd_data = 8'hA5;
  logic       limpar_dst = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] f;
    int         ox;
    int         oy;
    int         x0;
    int         y0;
    int         repulse_at;
  } vetor_t;

  vetor_t vetores [6];

  always #5 clock = ~clock;

  assign pixel_lido = rd_data;

  ampliacao_replicacao #(
    .LARGURA (L),
    .ALTURA  (A),
    .PIXEL_W (8)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .iniciar       (iniciar),
    .fator         (fator),
    .origem_x      (origem_x),
    .origem_y      (origem_y),
    .end_leitura   (end_leitura),
    .ler           (ler),
    .pixel_lido    (pixel_lido),
    .end_escrita   (end_escrita),
    .escrever      (escrever),
    .pixel_escrito (pixel_escrito),
    .ocupado       (ocupado),
    .concluido     (concluido),
    .erro          (erro)
  );

  // Synchronous source RAM and destination RAM models.
  always @(posedge clock) begin
    if (ler) rd_data <= src_mem[end_leitura];
    if (limpar_dst) begin
      for (int i = 0; i < N_PIX; i++) dst_mem[i] <= 8'hFF;
    end else if (escrever) begin
      dst_mem[end_escrita] <= pixel_escrito;
    end
  end

  task automatic check(input string nome, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nome);
    check({nome, "_ocupado"}, int'(ocupado), 0);
    check({nome, "_concluido"}, int'(concluido), 0);
    check({nome, "_erro"}, int'(erro), 0);
    check({nome, "_ler"}, int'(ler), 0);
    check({nome, "_escrever"}, int'(escrever), 0);
    check({nome, "_end_leitura"}, int'(end_leitura), 0);
    check({nome, "_end_escrita"}, int'(end_escrita), 0);
    check({nome, "_pixel_escrito"}, int'(pixel_escrito), 0);
  endtask

  task automatic run_frame(input vetor_t v, input string nome);
    int bad_rd;
    int bad_wr;
    int bad_oc;
    int nconc;
    int conc_at;
    int bad_px;
    int exp_addr;
    int idx;
    bad_rd = 0; bad_wr = 0; bad_oc = 0; nconc = 0; conc_at = -1; bad_px = 0;
    @(negedge clock);
    limpar_dst = 1'b1;
    @(negedge clock);
    limpar_dst = 1'b0;
    fator = v.f;
    origem_x = 3'(v.ox);
    origem_y = 2'(v.oy);
    iniciar = 1'b1;
    @(posedge clock);  // accept edge N
    #1;
    iniciar = 1'b0;
    check({nome, "_ocupado_on_accept"}, int'(ocupado), 1);
    for (int j = 1; j <= 40; j++) begin
      @(posedge clock);
      #1;
      if (iniciar) begin
        iniciar = 1'b0;
        fator = v.f;
        origem_x = 3'(v.ox);
        origem_y = 2'(v.oy);
      end
      if (ler !== (j <= N_PIX)) bad_rd++;
      if (j <= N_PIX) begin
        idx = j - 1;
        exp_addr = (v.y0 + ((idx / L) >> v.f)) * L + v.x0 + ((idx % L) >> v.f);
        if (int'(end_leitura) != exp_addr) bad_rd++;
      end
      if (escrever !== (j >= 2 && j <= N_PIX + 1)) bad_wr++;
      if (j >= 2 && j <= N_PIX + 1 && int'(end_escrita) != j - 2) bad_wr++;
      if (concluido === 1'b1) begin
        nconc++;
        conc_at = j;
      end
      if (ocupado !== (j < N_PIX + 2)) bad_oc++;
      if (j == v.repulse_at) begin
        iniciar = 1'b1;
        fator = (v.f == 2'd2) ? 2'd1 : 2'd2;
        origem_x = 3'd0;
        origem_y = 2'd0;
      end
    end
    check({nome, "_read_seq"}, bad_rd, 0);
    check({nome, "_write_seq"}, bad_wr, 0);
    check({nome, "_ocupado_seq"}, bad_oc, 0);
    check({nome, "_concluido_count"}, nconc, 1);
    check({nome, "_concluido_cycle"}, conc_at, N_PIX + 2);
    for (int y = 0; y < A; y++) begin
      for (int x = 0; x < L; x++) begin
        if (dst_mem[y * L + x] !== src_mem[(v.y0 + (y >> v.f)) * L + v.x0 + (x >> v.f)])
          bad_px++;
      end
    end
    check({nome, "_dest_image"}, bad_px, 0);
  endtask

  initial begin
    int viol;
    for (int i = 0; i < N_PIX; i++) src_mem[i] = 8'(i * 5 + 16);
    //            f     ox oy x0 y0 repulse
    vetores[0] = '{2'd1, 0, 0, 0, 0, 0};
    vetores[1] = '{2'd2, 6, 3, 6, 3, 0};
    vetores[2] = '{2'd1, 7, 3, 4, 2, 0};
    vetores[3] = '{2'd0, 5, 2, 0, 0, 0};
    vetores[4] = '{2'd2, 7, 0, 6, 0, 0};
    vetores[5] = '{2'd1, 7, 3, 4, 2, 5};

    // Reset state, with a nonzero value parked on pixel_lido.
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_frame(vetores[t], $sformatf("vec%0d", t));
    end

    // Explicit corner pixels for 2x at (0,0) and at clamped (7,3)->(4,2).
    run_frame(vetores[0], "x2_origin");
    check("x2_dest00", int'(dst_mem[0]), int'(src_mem[0]));
    check("x2_dest11", int'(dst_mem[1 * L + 1]), int'(src_mem[0]));
    check("x2_dest73", int'(dst_mem[3 * L + 7]), int'(src_mem[1 * L + 3]));
    run_frame(vetores[2], "x2_clamp");
    check("clamp_dest00", int'(dst_mem[0]), int'(src_mem[2 * L + 4]));

    // Reserved fator: one-cycle erro, nothing else moves.
    @(negedge clock);
    fator = 2'd3;
    origem_x = 3'd1;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    check("rsv_erro_pulse", int'(erro), 1);
    check("rsv_ocupado", int'(ocupado), 0);
    viol = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clock);
      #1;
      if (erro || ler || escrever || ocupado || concluido) viol++;
    end
    check("rsv_quiet_after", viol, 0);

    // Reset mid-frame at N+10 aborts the frame.
    @(negedge clock);
    fator = 2'd1;
    origem_x = 3'd0;
    origem_y = 2'd0;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("abort_ler_before", int'(ler), 1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_all_zero("abort");
    @(negedge clock);
    reset_n = 1'b1;
    viol = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clock);
      #1;
      if (ler || escrever || ocupado || concluido || erro) viol++;
    end
    check("abort_quiet_after", viol, 0);
    run_frame(vetores[1], "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
